// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, byte width and default timing constants for the UART feeder
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} tx_state_t;
  localparam int BYTE_W          = 8;
  localparam int GAP_DEFAULT     = 16;
  localparam int TIMEOUT_DEFAULT = 2000000;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO whose head is always visible on rd_data, with occupancy count
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_wr;
  logic             w_rd;
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign level   = r_wr_ptr - r_rd_ptr;
  assign full    = level[AW];
  assign empty   = level == '0;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];
  // storage carries no reset; the pointers alone define which entries are valid
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  // pointers keep one extra bit so a full FIFO differs from an empty one
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers host bytes and hands them one at a time to the UART transmitter
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = GAP_DEFAULT,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [BYTE_W-1:0]      wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [BYTE_W-1:0]      dintx,
  output logic                   send,
  input  logic                   donetx,
  output logic                   busy,
  output logic                   timeout_err
);
  localparam int CW = $clog2((TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES) + 1);
  tx_state_t         r_state;
  logic [CW-1:0]     r_cnt;
  logic [BYTE_W-1:0] r_dintx;
  logic              r_send;
  logic              r_timeout_err;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_prev;
  logic              w_done;
  logic [BYTE_W-1:0] w_head;
  assign w_done      = r_sync2 && !r_prev;
  assign busy        = r_state != IDLE;
  assign dintx       = r_dintx;
  assign send        = r_send;
  assign timeout_err = r_timeout_err;
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(BYTE_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (r_state == LOAD),
    .rd_data (w_head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );
  // donetx comes from the uclk domain; prev follows in every state so a level already high never reads as an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= donetx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  // feeder FSM: pop, request, wait for completion or timeout, then hold send low for the gap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_dintx       <= '0;
      r_send        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        IDLE: if (!empty) r_state <= LOAD;
        LOAD: begin
          r_dintx <= w_head;
          r_cnt   <= '0;
          r_send  <= 1'b1;
          r_state <= SEND;
        end
        SEND:
          if (w_done || r_cnt == CW'(TIMEOUT - 1)) begin
            r_timeout_err <= !w_done;
            r_send        <= 1'b0;
            r_cnt         <= '0;
            r_state       <= GAP;
          end else r_cnt <= r_cnt + 1'b1;
        GAP:
          if (r_cnt == CW'(GAP_CYCLES - 1)) r_state <= IDLE;
          else r_cnt <= r_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: self-checking bench with a transmitter model and a queue-based reference
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int GAP   = 16;
  localparam int TMO   = 120;
  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       wr_en   = 1'b0;
  logic       donetx  = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, send, busy, timeout_err;
  logic [4:0] level;
  logic [7:0] dintx;
  int         n_cmp   = 0;
  int         n_err   = 0;
  int         n_sends = 0;
  logic [7:0] exp_q[$];
  int         tx_mode = 1;
  int         tx_lat  = 100;
  int         t_cnt   = 1000000;
  logic       t_prev  = 1'b0;
  logic       m_prev  = 1'b0;
  typedef struct {
    logic       we;
    logic [7:0] d;
    logic       acc;
    int         lvl;
    logic       f;
    logic       e;
  } vec_t;
  vec_t tbl[18];

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .dintx       (dintx),
    .send        (send),
    .donetx      (donetx),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // every send rise must carry the oldest byte the model accepted
  always @(negedge clk) begin
    if (rst_n && send && !m_prev) begin
      n_sends++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_send: dintx %0h with nothing queued", dintx);
      end else chk("tx_byte", {24'd0, dintx}, {24'd0, exp_q.pop_front()});
    end
    m_prev = rst_n && send;
  end

  // transmitter model: mode 0 pulses donetx tx_lat cycles after send rises, 1 holds low, 2 holds high
  initial forever begin
    @(posedge clk);
    #2;
    if (send && !t_prev) t_cnt = 0;
    else if (t_cnt < 1000000) t_cnt++;
    t_prev = send;
    donetx = tx_mode == 1 ? 1'b0 : tx_mode == 2 ? 1'b1 : (t_cnt >= tx_lat && t_cnt < tx_lat + 3);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0, n, m_level, n_to;
    logic acc, last_acc, p_send;
    for (int i = 0; i < 16; i++) tbl[i] = '{1'b1, 8'(i + 1), 1'b1, i + 1, i == 15, 1'b0};
    tbl[16] = '{1'b1, 8'hFF, 1'b0, 16, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 16, 1'b1, 1'b0};

    tick(2);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_dintx", dintx, 0);
    chk("rst_send", send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst_n = 1'b1;
    tick(2);

    // single byte with a 100-cycle transmitter
    tx_mode = 0;
    tx_lat  = 100;
    t_cnt   = 1000000;
    exp_q.push_back(8'hA5);
    wr(8'hA5);
    chk("t1_empty", empty, 0);
    chk("t1_level", level, 1);
    tick();
    chk("t1_send_t2", send, 0);
    tick();
    chk("t1_send_t3", send, 1);
    chk("t1_dintx_t3", dintx, 8'hA5);
    t0 = 0;
    while (!donetx && t0 < 200) begin
      @(negedge clk);
      t0++;
    end
    chk("t1_donetx_seen", donetx, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (send && n < 10);
    chk("t1_send_fall_lat", n >= 3 && n <= 4, 1);
    repeat (GAP + 1) @(negedge clk);
    chk("t1_busy_end", busy, 0);
    chk("t1_level_end", level, 0);
    tick();

    // burst into a FIFO whose first byte is stuck in SEND
    tx_mode = 1;
    exp_q.push_back(8'hE7);
    wr(8'hE7);
    tick(3);
    chk("b_primer_send", send, 1);
    chk("b_primer_level", level, 0);
    for (int i = 0; i < 18; i++) begin
      wr_en   = tbl[i].we;
      wr_data = tbl[i].d;
      if (tbl[i].acc) exp_q.push_back(tbl[i].d);
      tick();
      chk($sformatf("b_level[%0d]", i), level, tbl[i].lvl);
      chk($sformatf("b_full[%0d]", i), full, tbl[i].f);
      chk($sformatf("b_empty[%0d]", i), empty, tbl[i].e);
    end
    wr_en = 1'b0;

    // write while full in the LOAD cycle is dropped
    tx_mode = 0;
    tx_lat  = 3;
    t_cnt   = 0;
    t0 = 0;
    while (busy && t0 < 300) begin
      tick();
      t0++;
    end
    chk("f_idle", busy, 0);
    chk("f_idle_level", level, 16);
    chk("f_idle_full", full, 1);
    tick();
    wr(8'h55);
    chk("f_level_after", level, 15);
    chk("f_full_after", full, 0);
    chk("f_send_after", send, 1);
    tx_lat = 7;
    t0 = 0;
    while ((exp_q.size() != 0 || busy) && t0 < 3000) begin
      tick();
      t0++;
    end
    chk("f_drain_q", exp_q.size(), 0);
    chk("f_drain_busy", busy, 0);

    // timeout with donetx held low
    tx_mode = 1;
    exp_q.push_back(8'h81);
    wr(8'h81);
    exp_q.push_back(8'h3C);
    wr(8'h3C);
    t0 = 0;
    while (!send && t0 < 10) begin
      tick();
      t0++;
    end
    chk("to_send", send, 1);
    chk("to_dintx", dintx, 8'h81);
    tick(TMO - 1);
    chk("to_err_early", timeout_err, 0);
    chk("to_send_early", send, 1);
    tick();
    chk("to_err_pulse", timeout_err, 1);
    chk("to_send_fall", send, 0);
    tick();
    chk("to_err_once", timeout_err, 0);
    tick(GAP);
    chk("to_gap_send", send, 0);
    tick();
    chk("to_next_send", send, 1);
    chk("to_next_dintx", dintx, 8'h3C);
    t0 = 0;
    while (!timeout_err && t0 < TMO + 5) begin
      tick();
      t0++;
    end
    chk("to_second_err", timeout_err, 1);
    t0 = 0;
    while (busy && t0 < 100) begin
      tick();
      t0++;
    end
    chk("to_idle", busy, 0);

    // donetx stuck high: no false completion, every byte times out
    tx_mode = 2;
    tick(5);
    exp_q.push_back(8'h11);
    wr(8'h11);
    exp_q.push_back(8'h22);
    wr(8'h22);
    n_to = 0;
    repeat (2 * (TMO + GAP + 4) + 20) begin
      tick();
      if (timeout_err) n_to++;
    end
    chk("h1_timeouts", n_to, 2);
    chk("h1_q", exp_q.size(), 0);
    chk("h1_busy", busy, 0);
    tx_mode = 0;
    t_cnt   = 1000000;
    tick(5);

    // random writes against the occupancy model
    m_level  = 0;
    last_acc = 1'b0;
    p_send   = 1'b0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (last_acc) m_level++;
      if (send && !p_send) begin
        m_level--;
        tx_lat = $urandom_range(2, 40);
      end
      p_send = send;
      chk("rnd_level", level, m_level);
      chk("rnd_full", full, m_level == DEPTH);
      chk("rnd_empty", empty, m_level == 0);
      wr_en    = $urandom_range(0, 2) == 0;
      wr_data  = 8'($urandom);
      acc      = wr_en && m_level < DEPTH;
      if (acc) exp_q.push_back(wr_data);
      last_acc = acc;
    end
    tick();
    wr_en = 1'b0;
    t0 = 0;
    while ((exp_q.size() != 0 || busy) && t0 < 3000) begin
      tick();
      t0++;
    end
    chk("rnd_drain_q", exp_q.size(), 0);
    chk("rnd_drain_busy", busy, 0);

    // reset in the middle of SEND with bytes queued
    tx_mode = 1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(8'hA0 + 8'(i));
      wr(8'hA0 + 8'(i));
    end
    chk("r_level_before", level, 5);
    chk("r_send_before", send, 1);
    tick(3);
    #3 rst_n = 1'b0;
    #1;
    chk("r_send", send, 0);
    chk("r_level", level, 0);
    chk("r_empty", empty, 1);
    chk("r_busy", busy, 0);
    exp_q.delete();
    t0 = n_sends;
    tick(2);
    rst_n = 1'b1;
    tick(60);
    chk("r_no_send", n_sends - t0, 0);
    chk("r_level_after", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
